fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that lets N requesters share the single write port of async_fifo_4x4. It runs in the write clock domain and grants one requester at a time for a burst of up to MAX_BURST beats. It drives the FIFO's wr_en/din directly and honours its full flag. Each requester uses a valid/ack handshake, so no data is lost or duplicated.

Parameters:
N, 4, number of requesters (2..8)
W, 4, data width; matches FIFO din width
MAX_BURST, 4, max beats per grant before forced re-arbitration (1..15)

Ports:
wr_clk  input  1  write-domain clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  req[i]=1: requester i has a valid beat on its data slice
req_data  input  N*W  packed data; slice i = req_data[i*W +: W]
ack  output  N  one-hot; ack[i]=1 means the beat from i is written this cycle
gnt  output  N  one-hot current owner; 0 when not in BURST
busy  output  1  1 while in BURST
fifo_full  input  1  FIFO full flag (already in wr_clk domain)
fifo_wr_en  output  1  to FIFO wr_en
fifo_din  output  W  to FIFO din

Behaviour:
- States: IDLE, BURST. Registers: state, owner[log2N], last_owner, beat_cnt[3:0].
- Reset (async, rst_n=0): state=IDLE, owner=0, last_owner=N-1, beat_cnt=0.
- Outputs are combinational from state and registers, so reset forces gnt=0, busy=0, ack=0, fifo_wr_en=0 immediately. fifo_din is don't-care; drive 0 when not writing.
- IDLE: if |req, select the first i with req[i]=1, searching from last_owner+1 upward with wrap modulo N. Register it as owner, clear beat_cnt, and go to BURST next edge. No write occurs in IDLE, so arbitration costs exactly 1 cycle.
- BURST: accept = req[owner] & ~fifo_full.
  - fifo_wr_en = accept; fifo_din = slice owner; ack[owner] = accept; gnt[owner] = 1.
  - On accept: beat_cnt += 1.
  - Exit to IDLE (last_owner <= owner) at the edge where either:
    - accept occurs and beat_cnt == MAX_BURST-1, or
    - req[owner] == 0.
  - fifo_full=1 with req[owner]=1: stall. Stay in BURST with no write and no ack; beat_cnt is held. There is no timeout.
- Requester rules:
  - Hold req and data stable until ack.
  - Drop req only after the last ack.
  - A requester whose req rises while another owns the port waits for the next IDLE.
- Fairness: each requester gets at most MAX_BURST beats per turn. Worst-case wait is (N-1)*(MAX_BURST+1) cycles, excluding full stalls.
- Throughput: sustained single requester gives MAX_BURST writes per MAX_BURST+1 cycles.
- Simultaneous fifo_full rise and last beat: no accept, so no exit. The burst completes after full clears.
- req[owner] dropping while full: exit to IDLE with no write.

Optional Feature:
FIFO_WR_ARB_STATS_EN
- Defined: adds output port stall_cnt[15:0], a saturating count of BURST cycles with req[owner]=1 and fifo_full=1. It is cleared by rst_n and holds at 16'hFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Single requester: req[1]=1 with beats 0xA,0xB,0xC, then drop; fifo_full=0. Required: one IDLE cycle, then fifo_wr_en=1 for 3 consecutive cycles with fifo_din A,B,C and ack[1] pulsing 3 times. Return to IDLE, last_owner=1.
2. All four requesters continuous, MAX_BURST=2. Required: owner order 0,0,1,1,2,2,3,3,0,0, with exactly one idle cycle between bursts and 8 writes in 12 cycles.
3. Full stall: fifo_full=1 for 3 cycles after the 2nd beat of requester 0. Required: fifo_wr_en=0, ack=0, gnt[0] held, beat_cnt=2. After full clears, beats 3-4 are written and the burst ends. The beat total stays at 4.
4. Early drop: req[2] drops after 1 beat while req[3] and req[0] are pending. Required: IDLE next, then owner=3 (not 0).
5. Reset mid-burst: rst_n=0 during a write cycle. Required: fifo_wr_en, ack and gnt go to 0 before the next edge. After release with req=4'b1111, owner 0 wins first.
6. With FIFO_WR_ARB_STATS_EN defined: 5 stalled cycles give stall_cnt=5. With the macro undefined, the design elaborates without the port.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters; optional stall counter under FIFO_WR_ARB_STATS_EN.
// Latency: 1 idle arbitration cycle per grant, then one beat per cycle for up to MAX_BURST beats.
// Backpressure: fifo_full stalls the owner (no write, no ack, beat count held); owner dropping req ends the burst.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic           wr_clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   gnt,
    output logic           busy,
    input  logic           fifo_full,
    output logic           fifo_wr_en,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [W-1:0]   fifo_din,
    output logic [15:0]    stall_cnt
`else
    output logic [W-1:0]   fifo_din
`endif
);

    localparam int OW = $clog2(N);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_owner;
    logic [3:0]    beat_cnt;

    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          pick_vld;
    logic          accept;
    logic [N-1:0]  owner_oh;
    logic [W-1:0]  din_sel;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        pick     = '0;
        idx      = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = OW'((int'(last_owner) + k) % N);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == OW'(i)) begin
                din_sel = req_data[i*W +: W];
            end
        end
    end

    assign owner_oh   = {{(N-1){1'b0}}, 1'b1} << owner;
    assign busy       = (state == BURST);
    assign accept     = busy && req[owner] && !fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_din   = accept ? din_sel : '0;
    assign ack        = accept ? owner_oh : '0;
    assign gnt        = busy ? owner_oh : '0;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(N - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                default: begin
                    if (!req[owner]) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == 4'(MAX_BURST - 1)) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (busy && req[owner] && fifo_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes are queued per test and checked by a negedge monitor.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           wr_clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           fifo_full;

    logic [N-1:0] ack4, gnt4, ack2, gnt2;
    logic         busy4, busy2, wr_en4, wr_en2;
    logic [W-1:0] din4, din2;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]  stall4, stall2;
`endif

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut4 (
        .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack4), .gnt(gnt4), .busy(busy4), .fifo_full(fifo_full),
        .fifo_wr_en(wr_en4), .fifo_din(din4)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stall_cnt(stall4)
`endif
    );

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(2)) dut2 (
        .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack2), .gnt(gnt2), .busy(busy2), .fifo_full(fifo_full),
        .fifo_wr_en(wr_en2), .fifo_din(din2)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stall_cnt(stall2)
`endif
    );

    // sel picks which instance the requester model and monitor follow.
    logic         sel;
    logic         m_wr_en;
    logic [N-1:0] m_ack;
    logic [W-1:0] m_din;
    assign m_wr_en = sel ? wr_en2 : wr_en4;
    assign m_ack   = sel ? ack2   : ack4;
    assign m_din   = sel ? din2   : din4;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] ack;
        logic [W-1:0] din;
    } exp_t;

    exp_t         expq[$];
    exp_t         e;
    logic [W-1:0] rq [N][$];
    logic [N-1:0] ack_lat;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           wr_cnt = 0;
    int           full_lo = 0;
    int           full_hi = -1;

    always @(negedge wr_clk) begin
        ack_lat = m_ack;
        if (rst_n === 1'b1 && m_wr_en === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got cyc=%0d ack=%b din=%h, none required", cyc, m_ack, m_din);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || e.ack !== m_ack || e.din !== m_din) begin
                    miscompares++;
                    $display("FAIL write: got cyc=%0d ack=%b din=%h, required cyc=%0d ack=%b din=%h",
                             cyc, m_ack, m_din, e.cyc, e.ack, e.din);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input int who, input logic [W-1:0] d);
        exp_t x;
        x.cyc      = c;
        x.ack      = '0;
        x.ack[who] = 1'b1;
        x.din      = d;
        expq.push_back(x);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]             = (rq[i].size() > 0);
            req_data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (ack_lat[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        fifo_full = (cyc >= full_lo && cyc <= full_hi);
        drive();
    endtask

    task automatic sample();
        @(negedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        full_lo   = 0;
        full_hi   = -1;
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        @(posedge wr_clk);
        @(negedge wr_clk);
        rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
        cyc    = 0;
        wr_cnt = 0;
    endtask

    task automatic drain(input string name);
        check(name, expq.size(), 0);
    endtask

    initial begin
        sel       = 1'b0;
        rst_n     = 1'b0;
        req       = '1;
        req_data  = '0;
        fifo_full = 1'b0;
        #2;
        check("reset_busy", busy4, 0);
        check("reset_gnt", gnt4, 0);
        check("reset_ack", ack4, 0);
        check("reset_wr_en", wr_en4, 0);

        // Single requester, three beats.
        do_reset();
        rq[1].push_back(4'hA); rq[1].push_back(4'hB); rq[1].push_back(4'hC);
        drive();
        push_exp(1, 1, 4'hA); push_exp(2, 1, 4'hB); push_exp(3, 1, 4'hC);
        sample();
        check("t1_idle_cycle", busy4, 0);
        for (int c = 1; c <= 5; c++) step();
        sample();
        check("t1_back_idle", busy4, 0);
        check("t1_last_owner", dut4.last_owner, 1);
        drain("t1_drain");

        // Four requesters, MAX_BURST=2.
        sel = 1'b1;
        do_reset();
        rq[0].push_back(4'h0); rq[0].push_back(4'h1); rq[0].push_back(4'h2); rq[0].push_back(4'h3);
        rq[1].push_back(4'h4); rq[1].push_back(4'h5);
        rq[2].push_back(4'h8); rq[2].push_back(4'h9);
        rq[3].push_back(4'hC); rq[3].push_back(4'hD);
        drive();
        push_exp(1, 0, 4'h0);  push_exp(2, 0, 4'h1);
        push_exp(4, 1, 4'h4);  push_exp(5, 1, 4'h5);
        push_exp(7, 2, 4'h8);  push_exp(8, 2, 4'h9);
        push_exp(10, 3, 4'hC); push_exp(11, 3, 4'hD);
        push_exp(13, 0, 4'h2); push_exp(14, 0, 4'h3);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 3) begin
                sample();
                check("t2_gap_idle", busy2, 0);
            end
            if (c == 12) begin
                sample();
                check("t2_writes_in_12", wr_cnt, 8);
            end
        end
        sample();
        drain("t2_drain");
        sel = 1'b0;

        // Full stall after the second beat.
        do_reset();
        rq[0].push_back(4'h1); rq[0].push_back(4'h2); rq[0].push_back(4'h3); rq[0].push_back(4'h4);
        full_lo = 3;
        full_hi = 5;
        drive();
        push_exp(1, 0, 4'h1); push_exp(2, 0, 4'h2); push_exp(6, 0, 4'h3); push_exp(7, 0, 4'h4);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c >= 3 && c <= 5) begin
                sample();
                check("t3_stall_wr_en", wr_en4, 0);
                check("t3_stall_ack", ack4, 0);
                check("t3_stall_gnt", gnt4, 4'b0001);
                check("t3_stall_beat_cnt", dut4.beat_cnt, 2);
            end
            if (c == 8) begin
                sample();
                check("t3_burst_done", busy4, 0);
`ifdef FIFO_WR_ARB_STATS_EN
                check("t3_stall_cnt", stall4, 3);
`endif
            end
        end
        sample();
        drain("t3_drain");

        // Early drop by requester 2 while 3 and 0 wait.
        do_reset();
        rq[1].push_back(4'h5);
        rq[2].push_back(4'h6);
        drive();
        push_exp(1, 1, 4'h5); push_exp(4, 2, 4'h6); push_exp(7, 3, 4'h7); push_exp(10, 0, 4'h8);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 2) begin
                rq[3].push_back(4'h7);
                rq[0].push_back(4'h8);
                drive();
            end
            if (c == 5) begin
                sample();
                check("t4_drop_gnt", gnt4, 4'b0100);
            end
            if (c == 6) begin
                sample();
                check("t4_idle_after_drop", busy4, 0);
            end
            if (c == 7) begin
                sample();
                check("t4_next_owner", gnt4, 4'b1000);
            end
        end
        sample();
        drain("t4_drain");

        // Reset during a write cycle.
        do_reset();
        rq[0].push_back(4'h1); rq[0].push_back(4'h2);
        rq[1].push_back(4'h3); rq[1].push_back(4'h4);
        rq[2].push_back(4'h5); rq[2].push_back(4'h6);
        rq[3].push_back(4'h7); rq[3].push_back(4'h8);
        drive();
        push_exp(2, 0, 4'h1); push_exp(3, 0, 4'h2); push_exp(6, 1, 4'h3); push_exp(7, 1, 4'h4);
        step();
        #1;
        check("t5_pre_wr_en", wr_en4, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en", wr_en4, 0);
        check("t5_rst_ack", ack4, 0);
        check("t5_rst_gnt", gnt4, 0);
        @(negedge wr_clk);
        #1;
        rst_n = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            step();
            if (c == 2) begin
                sample();
                check("t5_first_owner", gnt4, 4'b0001);
            end
        end
        sample();
        drain("t5_drain");

`ifdef FIFO_WR_ARB_STATS_EN
        // Five stalled cycles.
        do_reset();
        rq[0].push_back(4'h9);
        full_lo = 1;
        full_hi = 5;
        drive();
        push_exp(6, 0, 4'h9);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 6) begin
                sample();
                check("t6_stall_cnt", stall4, 5);
            end
        end
        sample();
        drain("t6_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
